seg_display_arbiter: RTL and testbench
======================================

# seg_display_arbiter

Time-shares the board's single 4-digit seven-segment display between two hex-value clients, for example the PS/2 scancode path and a status/colour path. A round-robin arbiter with a minimum-ownership hold time decides which client owns the display. The block latches the winner and drives the multiplexed anode/segment scan itself. It sits between the client modules and the top-level `seg`/`an`/`dp` pins.

## Interface
Parameters:
- `REFRESH_BITS`, default 18: each digit is lit for 2^REFRESH_BITS cycles.
- `HOLD_CYCLES`, default 25000000: minimum cycles an owner keeps the display under contention. Must be ≥1.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rstn`  in  1  asynchronous active-low reset.
- `req`  in  2  per-client request, level-sensitive; bit i = client i.
- `data0`  in  16  client 0 value, four hex digits; [3:0] goes to the rightmost digit.
- `data1`  in  16  client 1 value, same layout.
- `gnt`  out  2  one-hot grant, registered; never 2'b11.
- `seg`  out  7  active-low segments {g,f,e,d,c,b,a}, registered.
- `an`  out  4  active-low anodes, registered; an[0] = rightmost digit.
- `dp`  out  1  decimal point, active-low; held 1 (off).
- `busy`  out  1  high while any client owns the display.

## Operation
- The FSM has three states: IDLE, OWN0 and OWN1. A round-robin pointer `rr` names the preferred client; it resets to 0.
- IDLE transitions:
  - one request only → that client's OWN state.
  - both requests → OWN`rr`.
  - none → stay in IDLE.
- Entering OWNx: load the hold counter with HOLD_CYCLES-1 and set `rr` to the other client.
- In OWNx, the hold counter decrements each cycle and saturates at 0.
- OWNx transitions, in priority order:
  - `req[x]`=0 → IDLE, regardless of the hold counter.
  - hold counter =0 and `req[other]`=1 → OWN other; the counter reloads.
  - otherwise stay; ownership is unlimited while uncontested.
- `gnt` = one-hot of the state; `busy` = state≠IDLE.
- Scan logic:
  - A free-running counter `clkdiv` of width REFRESH_BITS+2 runs from reset.
  - `clkdiv[REFRESH_BITS+1:REFRESH_BITS]` selects the digit, in order 0,1,2,3,0...
- Display output:
  - Nibble i of the owner's data is shown on `an[i]`=0, with all other anodes at 1.
  - The owner's data is sampled live; it is not latched at grant.
- Hex decode (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- In IDLE, `an`=1111 and `seg`=1111111; the scan counter keeps running.

## Timing
- Reset values: state IDLE, `rr`=0, hold counter 0, `clkdiv`=0, `gnt`=00, `busy`=0, `an`=1111, `seg`=1111111, `dp`=1.
- A request sampled at edge N produces `gnt` high after edge N.
- A grant change at edge N produces `an`/`seg` showing the new owner after edge N+1.
- When the owner drops `req` at edge N, `gnt` falls after edge N and the display blanks after edge N+1.
- A switch under contention occurs exactly HOLD_CYCLES cycles after entry into OWNx.
  - There is no IDLE gap between owners.
  - `gnt` goes directly from 01 to 10, or from 10 to 01.
- Reset asserted mid-ownership:
  - All registers return to their reset values immediately.
  - After release, arbitration restarts with `rr`=0.
- Both requests rising in the same cycle → the client named by `rr` wins.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN`:
  - Defined: while the owner's value is shown, digits above its most significant non-zero nibble are blanked. The anode is still scanned, but `seg`=1111111 for those digits. Digit 0 is never blanked, so 0x0000 displays as "0".
  - Undefined: all four digits always show their hex value, leading zeros included.

## Test plan
(bench uses REFRESH_BITS=2, HOLD_CYCLES=8)
- Reset, then `req`=01 with `data0`=16'h12AF → `gnt`=01 next cycle. The scan then shows `an`=1110/F, 1101/A, 1011/2, 0111/1, with each digit held 4 cycles.
- `req`=11 in the same cycle straight after reset → `gnt`=01. `gnt`=10 exactly 8 cycles after the grant, and 01 again 8 cycles later.
- Client 0 owns, then `req[0]` drops at cycle 3 of hold → `gnt`=00 next cycle, `busy`=0, and `an`=1111 one cycle after that.
- Client 1 owns with `req[1]` held and client 0 never requesting for 100 cycles → `gnt` stays 10 throughout.
- `rstn` pulsed low mid-OWN1 → `gnt`=00 and `an`=1111 immediately. With `req`=11 after release, `gnt`=01.
- Macro defined, `data0`=16'h000B → digits 3..1 show `seg`=1111111 and digit 0 shows 0000011. With `data0`=16'h0000, digit 0 shows 1000000.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//
// Shares one 4-digit multiplexed seven-segment display between two hex-value
// clients. A three-state arbiter (IDLE / OWN0 / OWN1) with a round-robin
// preference pointer and a minimum-ownership hold counter picks the owner.
// The owner's 16-bit value is sampled live and scanned out one digit at a
// time onto the active-low anode/segment pins.
//
// Ports:
//   clk    in   1   system clock
//   rstn   in   1   asynchronous active-low reset
//   req    in   2   level-sensitive request, bit i = client i
//   data0  in  16   client 0 value, [3:0] = rightmost digit
//   data1  in  16   client 1 value, same layout
//   gnt    out  2   registered one-hot grant (never 2'b11)
//   seg    out  7   registered active-low segments {g,f,e,d,c,b,a}
//   an     out  4   registered active-low anodes, an[0] = rightmost digit
//   dp     out  1   decimal point, active-low, always off (1)
//   busy   out  1   high while a client owns the display
//
// gnt and busy together fully encode the arbiter state (00/0 = IDLE,
// 01/1 = OWN0, 10/1 = OWN1), so they double as the FSM state observation.
//
// Handshake: req is a level, not a pulse. A client owns the display for as
// long as gnt[i] is high; it releases ownership by dropping req[i]. There is
// no ready/ack back-pressure: the grant is the only response.
//
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//   When defined, digits above the owner's most significant non-zero nibble
//   are blanked (anode still scanned, segments all off). Digit 0 is never
//   blanked. When undefined, all four digits always show their hex value.
//
// Parameters:
//   REFRESH_BITS  each digit is lit for 2**REFRESH_BITS cycles
//   HOLD_CYCLES   minimum ownership under contention, must be >= 1

module seg_display_arbiter #(
  parameter int REFRESH_BITS = 18,
  parameter int HOLD_CYCLES  = 25000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  gnt,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        busy
);

  // Hold counter only needs to represent HOLD_CYCLES-1.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam int DIV_W = REFRESH_BITS + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Arbiter state
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [1:0]          gnt_d;
  logic                busy_d;

  // Hold counter value for a stay cycle: count down, stop at zero.
  logic [HOLD_W-1:0]   hold_dec;
  assign hold_dec = (hold_q == '0) ? '0 : (hold_q - HOLD_W'(1));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    hold_d  = hold_q;

    case (state_q)
      S_IDLE: begin
        // A single requester wins outright; a tie goes to the rr pointer.
        if (req == 2'b01 || (req == 2'b11 && !rr_q)) begin
          state_d = S_OWN0;
          hold_d  = HOLD_LOAD;
          rr_d    = 1'b1;
        end else if (req == 2'b10 || (req == 2'b11 && rr_q)) begin
          state_d = S_OWN1;
          hold_d  = HOLD_LOAD;
          rr_d    = 1'b0;
        end
      end

      S_OWN0: begin
        // Owner release beats everything, even an unexpired hold.
        if (!req[0]) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end else if (hold_q == '0 && req[1]) begin
          // Direct hand-over, no IDLE bubble between owners.
          state_d = S_OWN1;
          hold_d  = HOLD_LOAD;
          rr_d    = 1'b0;
        end else begin
          hold_d  = hold_dec;
        end
      end

      S_OWN1: begin
        if (!req[1]) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end else if (hold_q == '0 && req[0]) begin
          state_d = S_OWN0;
          hold_d  = HOLD_LOAD;
          rr_d    = 1'b1;
        end else begin
          hold_d  = hold_dec;
        end
      end

      default: begin
        state_d = S_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_comb begin
    gnt_d  = 2'b00;
    busy_d = 1'b0;
    case (state_d)
      S_OWN0: begin
        gnt_d  = 2'b01;
        busy_d = 1'b1;
      end
      S_OWN1: begin
        gnt_d  = 2'b10;
        busy_d = 1'b1;
      end
      default: begin
        gnt_d  = 2'b00;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      hold_q  <= '0;
      gnt     <= 2'b00;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      gnt     <= gnt_d;
      busy    <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Scan / display path
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] clkdiv_q, clkdiv_d;
  logic [1:0]       digit_sel;
  logic [15:0]      owner_data;
  logic [3:0]       nibble;
  logic             digit_blank;
  logic [6:0]       seg_d;
  logic [3:0]       an_d;

  assign clkdiv_d  = clkdiv_q + DIV_W'(1);
  assign digit_sel = clkdiv_q[DIV_W-1 -: 2];

  // Display follows the registered state, so a grant change reaches the pins
  // one edge after gnt does.
  assign owner_data = (state_q == S_OWN1) ? data1 : data0;
  assign nibble     = owner_data[{digit_sel, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Index of the most significant non-zero nibble; zero when the value is 0,
  // which keeps digit 0 lit so 0x0000 shows a single "0".
  logic [1:0] msd_idx;
  always_comb begin
    msd_idx = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (owner_data[i*4 +: 4] != 4'h0) begin
        msd_idx = 2'(i);
      end
    end
  end
  assign digit_blank = (digit_sel > msd_idx);
`else
  assign digit_blank = 1'b0;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    if (state_q != S_IDLE) begin
      an_d  = ~(4'b0001 << digit_sel);
      seg_d = digit_blank ? 7'b1111111 : hex7(nibble);
    end
  end

  // The scan counter free-runs in every state, including IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clkdiv_q <= '0;
      an       <= 4'b1111;
      seg      <= 7'b1111111;
    end else begin
      clkdiv_q <= clkdiv_d;
      an       <= an_d;
      seg      <= seg_d;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter with REFRESH_BITS=2, HOLD_CYCLES=8.
// Clock/reset block, driver tasks, expected-value queues for grant and
// display, a hex-decode vector table, and a final summary line.

module tb_seg_display_arbiter;

  localparam int RB = 2;
  localparam int HC = 8;

  // ---------------- clock / reset ----------------
  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req  = 2'b00;
  logic [15:0] data0 = 16'h0000;
  logic [15:0] data1 = 16'h0000;
  logic [1:0]  gnt;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        busy;

  always #5 clk = ~clk;

  seg_display_arbiter #(.REFRESH_BITS(RB), .HOLD_CYCLES(HC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .req  (req),
    .data0(data0),
    .data1(data1),
    .gnt  (gnt),
    .seg  (seg),
    .an   (an),
    .dp   (dp),
    .busy (busy)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_q[$];      // {an, seg}
  logic [2:0]  gnt_exp_q[$];  // {gnt, busy}

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } hex_vec_t;
  hex_vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    return vecs[n].seg;
  endfunction

  // Expected {an,seg} for an owned value with scan counter value cd before the edge.
  function automatic logic [10:0] exp_disp(input logic [15:0] val, input int cd, input bit owned);
    logic [1:0] d;
    logic [1:0] msd;
    logic [6:0] s;
    logic [3:0] a;
    if (!owned) return {4'b1111, 7'b1111111};
    d = 2'((cd >> RB) & 3);
    a = ~(4'b0001 << d);
    s = ref_seg(val[d*4 +: 4]);
    msd = 2'd0;
    for (int i = 1; i < 4; i++) if (val[i*4 +: 4] != 4'h0) msd = 2'(i);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (d > msd) s = 7'b1111111;
`endif
    return {a, s};
  endfunction

  task automatic pop_disp(input string name);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: display queue empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {21'h0, an, seg}, {21'h0, e});
    end
  endtask

  task automatic pop_gnt(input string name);
    logic [2:0] e;
    if (gnt_exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: grant queue empty", name);
    end else begin
      e = gnt_exp_q.pop_front();
      check(name, {29'h0, gnt, busy}, {29'h0, e});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Hold reset for two cycles, check reset outputs, then release on a
  // falling edge with the requested req value so the next rising edge is
  // the first functional edge (scan counter = 0 before it).
  task automatic do_reset(input logic [1:0] req_after);
    rstn = 1'b0;
    req  = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_outputs", {20'h0, gnt, busy, an, seg, dp}, {20'h0, 2'b00, 1'b0, 4'b1111, 7'b1111111, 1'b1});
    rstn = 1'b1;
    req  = req_after;
  endtask

  // Called right after do_reset with a single client requesting.
  task automatic scan_check(input logic [15:0] val, input int n_edges, input string name);
    for (int k = 1; k <= n_edges; k++) begin
      exp_q.push_back(exp_disp(val, k - 1, k > 1));
      tick();
      pop_disp(name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'h0, 7'b1000000};
    vecs[1]  = '{4'h1, 7'b1111001};
    vecs[2]  = '{4'h2, 7'b0100100};
    vecs[3]  = '{4'h3, 7'b0110000};
    vecs[4]  = '{4'h4, 7'b0011001};
    vecs[5]  = '{4'h5, 7'b0010010};
    vecs[6]  = '{4'h6, 7'b0000010};
    vecs[7]  = '{4'h7, 7'b1111000};
    vecs[8]  = '{4'h8, 7'b0000000};
    vecs[9]  = '{4'h9, 7'b0010000};
    vecs[10] = '{4'hA, 7'b0001000};
    vecs[11] = '{4'hB, 7'b0000011};
    vecs[12] = '{4'hC, 7'b1000110};
    vecs[13] = '{4'hD, 7'b0100001};
    vecs[14] = '{4'hE, 7'b0000110};
    vecs[15] = '{4'hF, 7'b0001110};

    // 1. Client 0 alone, scan order of 12AF.
    data0 = 16'h12AF;
    data1 = 16'h3C5D;
    do_reset(2'b01);
    gnt_exp_q.push_back({2'b01, 1'b1});
    exp_q.push_back(exp_disp(16'h12AF, 0, 1'b0));
    tick();
    pop_gnt("first_grant");
    pop_disp("scan_first_edge_blank");
    for (int k = 2; k <= 20; k++) begin
      exp_q.push_back(exp_disp(16'h12AF, k - 1, 1'b1));
      tick();
      pop_disp("scan_12AF");
    end
    check("dp_off", {31'h0, dp}, 32'h1);

    // 2. Hex decode table, each value replicated across all digits.
    for (int i = 0; i < 16; i++) begin
      logic [6:0] s;
      data0 = {4{vecs[i].nib}};
      tick();
      tick();
      s = vecs[i].seg;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (vecs[i].nib == 4'h0 && an != 4'b1110) s = 7'b1111111;
`endif
      check("hex_decode", {25'h0, seg}, {25'h0, s});
    end

    // 3. Both clients request straight after reset: 0 wins, swap every 8.
    do_reset(2'b11);
    for (int k = 1; k <= 20; k++) begin
      if (k <= HC)          gnt_exp_q.push_back({2'b01, 1'b1});
      else if (k <= 2 * HC) gnt_exp_q.push_back({2'b10, 1'b1});
      else                  gnt_exp_q.push_back({2'b01, 1'b1});
      tick();
      pop_gnt("contention_rr");
    end

    // 4. Owner drops request during the hold.
    data0 = 16'h12AF;
    do_reset(2'b01);
    gnt_exp_q.push_back({2'b01, 1'b1});
    tick();
    pop_gnt("drop_grant");
    tick();
    tick();
    req = 2'b00;
    gnt_exp_q.push_back({2'b00, 1'b0});
    exp_q.push_back(exp_disp(16'h12AF, 3, 1'b1));
    tick();
    pop_gnt("drop_gnt_falls");
    pop_disp("drop_display_lags");
    exp_q.push_back({4'b1111, 7'b1111111});
    tick();
    pop_disp("drop_display_blank");

    // 5. Client 1 uncontested for 100 cycles.
    data1 = 16'h5555;
    do_reset(2'b10);
    for (int k = 1; k <= 100; k++) begin
      gnt_exp_q.push_back({2'b10, 1'b1});
      tick();
      pop_gnt("uncontested_own1");
      if (k == 5) check("own1_seg", {25'h0, seg}, {25'h0, ref_seg(4'h5)});
    end

    // 6. Reset mid-OWN1 is immediate; rr restarts at 0.
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("async_reset_own1", {25'h0, gnt, busy, an}, {25'h0, 2'b00, 1'b0, 4'b1111});
    req = 2'b11;
    @(negedge clk);
    rstn = 1'b1;
    gnt_exp_q.push_back({2'b01, 1'b1});
    tick();
    pop_gnt("after_reset_rr0");

    // 7. Reset mid-OWN0 (rr now 1) must also restore rr to 0.
    tick();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("async_reset_own0", {25'h0, gnt, busy, an}, {25'h0, 2'b00, 1'b0, 4'b1111});
    @(negedge clk);
    rstn = 1'b1;
    gnt_exp_q.push_back({2'b01, 1'b1});
    tick();
    pop_gnt("rr_reset_restart");

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // 8. Leading-zero blanking.
    data0 = 16'h000B;
    do_reset(2'b01);
    scan_check(16'h000B, 20, "lzb_000B");
    data0 = 16'h0000;
    do_reset(2'b01);
    scan_check(16'h0000, 20, "lzb_0000");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
